timer_core: RTL and testbench

- mm:ss BCD timer consumed directly downstream of the tick divider.
- Advances one second per single-cycle `tick` enable.
- Runs as a stopwatch (count up) or a countdown with alarm.
- Provides BCD digits to the display mux and status flags to the LED/buzzer logic.
- Control pulses come from the synchronous button debouncer.

---
 rtl/timer_pkg.sv | 30 +++
 rtl/bcd_digit.sv | 41 ++++
 rtl/timer_core.sv | 124 ++++++++++++
 tb/tb_timer_core.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module : timer_pkg
// Brief  : Shared types and constants for the mm:ss BCD timer.
// Rev    : 1.0  initial release
// ============================================================================
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

  function automatic logic preset_valid(input logic [15:0] p, input int max_min);
    int minutes;
    minutes = 10 * int'(p[15:12]) + int'(p[11:8]);
    return (p[15:12] <= DIGIT_MAX) && (p[11:8] <= DIGIT_MAX) &&
           (p[7:4] <= SEC_TENS_MAX) && (p[3:0] <= DIGIT_MAX) &&
           (minutes <= max_min);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module : bcd_digit
// Brief  : One up/down BCD digit; wraps at limit (up) or 0 (down) with carry.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_digit
  import timer_pkg::*;
(
  input  logic en,
  input  logic dir,
  input  bcd_t limit,
  input  bcd_t value,
  output bcd_t value_next,
  output logic carry
);

  always_comb begin
    value_next = value;
    carry      = 1'b0;
    if (en) begin
      if (!dir) begin
        if (value >= limit) begin
          value_next = '0;
          carry      = 1'b1;
        end else begin
          value_next = value + 4'd1;
        end
      end else begin
        if (value == '0) begin
          value_next = limit;
          carry      = 1'b1;
        end else begin
          value_next = value - 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_core.sv
`default_nettype none
// ============================================================================
// Module : timer_core
// Brief  : mm:ss BCD stopwatch / countdown timer with alarm pulse.
// Rev    : 1.0  initial release
// ============================================================================
module timer_core
  import timer_pkg::*;
#(
  parameter int MAX_MIN   = 99,
  parameter int ALARM_LEN = 1
) (
  input  logic        clk_input,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        load,
  input  logic        mode_down,
  input  logic [15:0] preset,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        alarm,
  output logic        load_err
);

  localparam logic [15:0] TOP_COUNT  = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10), SEC_TENS_MAX, DIGIT_MAX};
  localparam logic [7:0]  ALARM_LAST = 8'(ALARM_LEN - 1);

  state_t      state;
  state_t      state_nxt;
  logic        dir;
  logic        dir_nxt;
  logic [15:0] digits_nxt;
  logic        err_nxt;
  logic [7:0]  alarm_cnt;
  logic [15:0] counted;
  logic [3:0]  cy;
  logic [3:0]  en_chain;

  assign en_chain = {cy[2:0], 1'b1};

  for (genvar i = 0; i < 4; i++) begin : g_digit
    localparam bcd_t LIM = (i == 1) ? SEC_TENS_MAX : DIGIT_MAX;
    bcd_digit u_digit (
      .en         (en_chain[i]),
      .dir        (dir),
      .limit      (LIM),
      .value      (digits[4*i +: 4]),
      .value_next (counted[4*i +: 4]),
      .carry      (cy[i])
    );
  end

  // Priority: clear > load > start_stop > tick.
  always_comb begin
    state_nxt  = state;
    dir_nxt    = dir;
    digits_nxt = digits;
    err_nxt    = 1'b0;
    if (clear) begin
      state_nxt  = IDLE;
      digits_nxt = '0;
    end else if (load && state != RUN) begin
      if (preset_valid(preset, MAX_MIN)) begin
        digits_nxt = preset;
        state_nxt  = IDLE;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (start_stop) begin
      case (state)
        IDLE: begin
          dir_nxt   = mode_down;
          state_nxt = (mode_down && digits == '0) ? DONE : RUN;
        end
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end else if (tick && state == RUN) begin
      // Already at a limit (e.g. preset of MAX_MIN:59): saturate rather than wrap.
      if ((!dir && digits == TOP_COUNT) || cy[3]) begin
        state_nxt = DONE;
      end else begin
        digits_nxt = counted;
        if (counted == (dir ? 16'h0000 : TOP_COUNT)) state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk_input or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir       <= 1'b0;
      digits    <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      alarm     <= 1'b0;
      alarm_cnt <= '0;
      load_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      digits   <= digits_nxt;
      running  <= (state_nxt == RUN);
      done     <= (state_nxt == DONE);
      load_err <= err_nxt;
      if (clear) begin
        alarm     <= 1'b0;
        alarm_cnt <= '0;
      end else if (state_nxt == DONE && state != DONE) begin
        alarm     <= 1'b1;
        alarm_cnt <= ALARM_LAST;
      end else if (alarm) begin
        if (alarm_cnt == '0) alarm <= 1'b0;
        else                 alarm_cnt <= alarm_cnt - 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_core.sv
`default_nettype none
// ============================================================================
// Module : tb_timer_core
// Brief  : Vector table, directed corner sequences and randomized model check.
// Rev    : 1.0  initial release
// ============================================================================
module tb_timer_core;

  localparam int MAX_MIN = 99;
  localparam int ALEN    = 3;
  localparam int MAXT    = MAX_MIN * 60 + 59;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n, tick, start_stop, clear, load, mode_down;
  logic [15:0] preset;
  logic [15:0] digits;
  logic        running, done, alarm, load_err;

  int total_n = 0;
  int bad_n   = 0;

  int   m_state, m_total, m_alarm;
  logic m_dir, m_err;

  timer_core #(.MAX_MIN(MAX_MIN), .ALARM_LEN(ALEN)) dut (
    .clk_input  (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .start_stop (start_stop),
    .clear      (clear),
    .load       (load),
    .mode_down  (mode_down),
    .preset     (preset),
    .digits     (digits),
    .running    (running),
    .done       (done),
    .alarm      (alarm),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        t, ss, c, l, m;
    logic [15:0] p;
    logic [15:0] d;
    logic        r, dn, a, e;
    string       name;
  } vec_t;

  function automatic vec_t mk(logic t, logic ss, logic c, logic l, logic m, logic [15:0] p,
                              logic [15:0] d, logic r, logic dn, logic a, logic e, string name);
    vec_t v;
    v.t = t; v.ss = ss; v.c = c; v.l = l; v.m = m; v.p = p;
    v.d = d; v.r = r; v.dn = dn; v.a = a; v.e = e; v.name = name;
    return v;
  endfunction

  function automatic int bcd2sec(logic [15:0] p);
    return (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
  endfunction

  function automatic logic [15:0] sec2bcd(int t);
    int mi, se;
    mi = t / 60;
    se = t % 60;
    return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
  endfunction

  function automatic logic ref_valid(logic [15:0] p);
    if (p[15:12] > 9 || p[11:8] > 9 || p[7:4] > 5 || p[3:0] > 9) return 1'b0;
    return (int'(p[15:12]) * 10 + int'(p[11:8])) <= MAX_MIN;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_total = 0; m_alarm = 0; m_dir = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic t, input logic ss, input logic c, input logic l,
                            input logic m, input logic [15:0] p);
    logic enter;
    enter = 1'b0;
    m_err = 1'b0;
    if (c) begin
      m_state = S_IDLE; m_total = 0;
    end else if (l && m_state != S_RUN) begin
      if (ref_valid(p)) begin m_total = bcd2sec(p); m_state = S_IDLE; end
      else m_err = 1'b1;
    end else if (ss) begin
      if (m_state == S_IDLE) begin
        m_dir = m;
        if (m && m_total == 0) begin m_state = S_DONE; enter = 1'b1; end
        else m_state = S_RUN;
      end else if (m_state == S_RUN) m_state = S_PAUSE;
      else if (m_state == S_PAUSE) m_state = S_RUN;
    end else if (t && m_state == S_RUN) begin
      if (m_dir) begin
        m_total = m_total - 1;
        if (m_total == 0) begin m_state = S_DONE; enter = 1'b1; end
      end else begin
        if (m_total < MAXT) m_total = m_total + 1;
        if (m_total == MAXT) begin m_state = S_DONE; enter = 1'b1; end
      end
    end
    if (c) m_alarm = 0;
    else if (enter) m_alarm = ALEN;
    else if (m_alarm > 0) m_alarm = m_alarm - 1;
  endtask

  task automatic drive(input logic t, input logic ss, input logic c, input logic l,
                       input logic m, input logic [15:0] p);
    tick = t; start_stop = ss; clear = c; load = l; mode_down = m; preset = p;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] d, input logic r,
                       input logic dn, input logic a, input logic e);
    total_n++;
    if (digits !== d || running !== r || done !== dn || alarm !== a || load_err !== e) begin
      bad_n++;
      $display("FAIL %s: got digits=%h run=%b done=%b alarm=%b err=%b, want digits=%h run=%b done=%b alarm=%b err=%b",
               name, digits, running, done, alarm, load_err, d, r, dn, a, e);
    end
  endtask

  task automatic ticks(input int n, input logic m);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b0, 1'b0, m, 16'h0);
  endtask

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; tick = 0; start_stop = 0; clear = 0; load = 0; mode_down = 0; preset = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 16'h0000, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    //           t  ss c  l  m  preset     digits    r  dn a  e
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, "idle"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0160, 16'h0000, 0, 0, 0, 1, "bad_sec_tens"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, "err_one_cycle"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0005, 16'h0005, 0, 0, 0, 0, "load_0005"));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0005, 1, 0, 0, 0, "start_up"));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 16'h0005, 0, 0, 0, 0, "pause_beats_tick"));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0005, 0, 0, 0, 0, "tick_in_pause"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 16'h0005, 1, 0, 0, 0, "resume"));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h0000, 16'h0006, 1, 0, 0, 0, "dir_kept_up"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0100, 16'h0006, 1, 0, 0, 0, "load_in_run"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0200, 16'h0000, 0, 0, 0, 0, "clear_over_load"));
    vecs.push_back(mk(0, 0, 0, 1, 1, 16'h0001, 16'h0001, 0, 0, 0, 0, "load_0001"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0, 0, "start_down"));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1, 0, "down_to_zero"));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1, 0, "alarm_2"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1, 0, "ss_in_done"));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0, "alarm_ends"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h9958, 16'h9958, 0, 0, 0, 0, "load_from_done"));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h9958, 1, 0, 0, 0, "start_sat"));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h9959, 0, 1, 1, 0, "reach_top"));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h9959, 0, 1, 1, 0, "no_wrap"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, "clear_kills_alarm"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1, 0, "down_from_zero"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'hA000, 16'h0000, 0, 1, 1, 1, "bad_digit_in_done"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, "alarm_3"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 16'h5959, 16'h5959, 0, 0, 0, 0, "load_5959"));

    foreach (vecs[i]) begin
      drive(vecs[i].t, vecs[i].ss, vecs[i].c, vecs[i].l, vecs[i].m, vecs[i].p);
      check(vecs[i].name, vecs[i].d, vecs[i].r, vecs[i].dn, vecs[i].a, vecs[i].e);
    end

    // Asynchronous reset between edges while running.
    drive(0, 1, 0, 0, 0, 16'h0);
    ticks(2, 1'b0);
    check("run_before_reset", 16'h6001, 1, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 16'h0000, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(3, 1'b0);
    check("idle_after_reset", 16'h0000, 0, 0, 0, 0);

    // Stopwatch from 00:00.
    drive(0, 1, 0, 0, 0, 16'h0);
    ticks(61, 1'b0);
    check("sw_0101", 16'h0101, 1, 0, 0, 0);
    ticks(538, 1'b0);
    check("sw_0959", 16'h0959, 1, 0, 0, 0);
    ticks(1, 1'b0);
    check("sw_1000", 16'h1000, 1, 0, 0, 0);

    // Countdown from 01:02.
    drive(0, 0, 1, 0, 0, 16'h0);
    drive(0, 0, 0, 1, 1, 16'h0102);
    drive(0, 1, 0, 0, 1, 16'h0);
    ticks(61, 1'b1);
    check("cd_0001", 16'h0001, 1, 0, 0, 0);
    ticks(1, 1'b1);
    check("cd_done", 16'h0000, 0, 1, 1, 0);
    for (int k = 1; k < ALEN; k++) begin
      drive(0, 0, 0, 0, 1, 16'h0);
      check("cd_alarm_hold", 16'h0000, 0, 1, 1, 0);
    end
    drive(0, 0, 0, 0, 1, 16'h0);
    check("cd_alarm_off", 16'h0000, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 16'h0);
    ticks(3, 1'b1);
    check("cd_done_sticky", 16'h0000, 0, 1, 0, 0);

    // Randomized run against the seconds-count model.
    rst_n = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      logic t, ss, c, l, m;
      logic [15:0] p;
      t  = ($urandom_range(0, 9) < 7);
      ss = ($urandom_range(0, 19) == 0);
      c  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 29) == 0);
      m  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       p = sec2bcd(int'($urandom_range(0, MAXT)));
        1:       p = sec2bcd(MAXT - int'($urandom_range(0, 4)));
        2:       p = sec2bcd(int'($urandom_range(0, 4)));
        default: p = 16'($urandom);
      endcase
      drive(t, ss, c, l, m, p);
      model_step(t, ss, c, l, m, p);
      check($sformatf("rand_%0d", n), sec2bcd(m_total), m_state == S_RUN,
            m_state == S_DONE, m_alarm > 0, m_err);
    end

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
`default_nettype wire
